// File: rtl/led_pattern_sequencer.sv
// Memory-mapped LED pattern sequencer: CPU-programmed static, blinking or rotating
// 16-bit patterns, pushed to the LED driver as one-cycle write strobes.
module led_pattern_sequencer #(
   parameter int unsigned          DIV_WIDTH      = 24,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_PERIOD = DIV_WIDTH'(5000000)
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [1:0]  Addr,
   input  logic [31:0] WD,
   input  logic        WE,
   output logic [31:0] RD,
   output logic [31:0] LedWD,
   output logic        LedWE
);

   typedef enum logic [1:0] {
      StOff    = 2'd0,
      StStatic = 2'd1,
      StBlink  = 2'd2,
      StShift  = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_dir, w_dir_nxt;
   logic [15:0]            r_pattern, w_pattern_nxt;
   logic [DIV_WIDTH-1:0]   r_period, w_period_nxt;
   logic [15:0]            r_cur, w_cur_nxt;
   logic                   r_phase, w_phase_nxt;
   logic [DIV_WIDTH-1:0]   r_cnt, w_cnt_nxt;
   logic                   r_led_we, w_led_we_nxt;

   logic                   w_wr;
   logic                   w_run;
   logic                   w_step;
   logic [DIV_WIDTH-1:0]   w_last;
   logic                   w_unused_wd;

   assign w_unused_wd = ^WD[31:16];

   assign w_wr   = WE && (Addr != 2'd3);
   assign w_run  = (r_state == StBlink) || (r_state == StShift);
   // A zero period behaves as one: step on every cycle.
   assign w_last = (r_period == '0) ? '0 : r_period - 1'b1;
   assign w_step = w_run && (r_cnt == w_last);

   always_comb begin
      w_state_nxt   = r_state;
      w_dir_nxt     = r_dir;
      w_pattern_nxt = r_pattern;
      w_period_nxt  = r_period;
      w_cur_nxt     = r_cur;
      w_phase_nxt   = r_phase;
      w_cnt_nxt     = r_cnt;
      w_led_we_nxt  = 1'b0;

      if (w_wr) begin
         // A CPU write re-enters the state with the freshly written registers;
         // any step due this cycle is dropped.
         case (Addr)
            2'd0: begin
               w_state_nxt = state_t'(WD[1:0]);
               w_dir_nxt   = WD[2];
            end
            2'd1:    w_pattern_nxt = WD[15:0];
            2'd2:    w_period_nxt  = WD[DIV_WIDTH-1:0];
            default: ;
         endcase
         w_cnt_nxt    = '0;
         w_phase_nxt  = (w_state_nxt == StBlink);
         w_cur_nxt    = (w_state_nxt == StOff) ? 16'h0000 : w_pattern_nxt;
         w_led_we_nxt = 1'b1;
      end else if (w_run) begin
         if (w_step) begin
            w_cnt_nxt    = '0;
            w_led_we_nxt = 1'b1;
            if (r_state == StBlink) begin
               w_phase_nxt = ~r_phase;
               w_cur_nxt   = r_phase ? 16'h0000 : r_pattern;
            end else if (r_dir) begin
               w_cur_nxt = {r_cur[0], r_cur[15:1]};
            end else begin
               w_cur_nxt = {r_cur[14:0], r_cur[15]};
            end
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end else begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state   <= StOff;
         r_dir     <= 1'b0;
         r_pattern <= 16'h0000;
         r_period  <= DEFAULT_PERIOD;
         r_cur     <= 16'h0000;
         r_phase   <= 1'b0;
         r_cnt     <= '0;
         r_led_we  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dir     <= w_dir_nxt;
         r_pattern <= w_pattern_nxt;
         r_period  <= w_period_nxt;
         r_cur     <= w_cur_nxt;
         r_phase   <= w_phase_nxt;
         r_cnt     <= w_cnt_nxt;
         r_led_we  <= w_led_we_nxt;
      end
   end

   always_comb begin
      RD = 32'h0000_0000;
      case (Addr)
         2'd0:    RD = {29'b0, r_dir, r_state};
         2'd1:    RD = {16'b0, r_pattern};
         2'd2:    RD = 32'(r_period);
         default: RD = {16'b0, r_cur};
      endcase
   end

   assign LedWD = {16'b0, r_cur};
   assign LedWE = r_led_we;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: a step-count reference model queues expected
// strobes, a negedge monitor pops and compares them against LedWE/LedWD.
module tb_led_pattern_sequencer;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic [1:0]  Addr = 2'd0;
   logic [31:0] WD = 32'h0;
   logic        WE = 1'b0;
   logic [31:0] RD;
   logic [31:0] LedWD;
   logic        LedWE;

   led_pattern_sequencer dut (
      .CLK   (CLK),
      .Reset (Reset),
      .Addr  (Addr),
      .WD    (WD),
      .WE    (WE),
      .RD    (RD),
      .LedWD (LedWD),
      .LedWE (LedWE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   // Reference model state: registers plus edges elapsed since the last state entry.
   logic [1:0]  m_mode = 2'd0;
   logic        m_dir = 1'b0;
   logic [15:0] m_pat = 16'h0;
   logic [23:0] m_per = 24'd5000000;
   logic [15:0] m_shown = 16'h0;
   int          m_k = 0;

   // Display value after s steps since entry.
   function automatic logic [15:0] model_val(int s);
      int x;
      int r;
      x = int'(m_pat);
      if (m_mode == 2'd2) return (s % 2 == 0) ? m_pat : 16'h0000;
      r = s % 16;
      if (m_dir) x = ((x >> r) | (x << (16 - r))) & 32'hFFFF;
      else       x = ((x << r) | (x >> (16 - r))) & 32'hFFFF;
      return x[15:0];
   endfunction

   function automatic logic [31:0] model_rd(logic [1:0] a);
      case (a)
         2'd0:    return {29'b0, m_dir, m_mode};
         2'd1:    return {16'b0, m_pat};
         2'd2:    return {8'b0, m_per};
         default: return {16'b0, m_shown};
      endcase
   endfunction

   always @(posedge CLK or negedge Reset) begin
      int   p;
      exp_t e;
      if (!Reset) begin
         m_mode = 2'd0; m_dir = 1'b0; m_pat = 16'h0; m_per = 24'd5000000;
         m_shown = 16'h0; m_k = 0;
         sb_q.delete();
      end else begin
         cyc++;
         if (WE && Addr != 2'd3) begin
            case (Addr)
               2'd0: begin m_mode = WD[1:0]; m_dir = WD[2]; end
               2'd1: m_pat = WD[15:0];
               default: m_per = WD[23:0];
            endcase
            m_k = 0;
            m_shown = (m_mode == 2'd0) ? 16'h0 : m_pat;
            e.cyc = cyc; e.val = m_shown;
            sb_q.push_back(e);
         end else if (m_mode >= 2'd2) begin
            m_k++;
            p = (m_per == 24'd0) ? 1 : int'(m_per);
            if (m_k % p == 0) begin
               m_shown = model_val(m_k / p);
               e.cyc = cyc; e.val = m_shown;
               sb_q.push_back(e);
            end
         end
      end
   end

   always @(negedge CLK) begin
      logic exp_we;
      exp_t e;
      if (!Reset) begin
         checks++;
         if (LedWE !== 1'b0 || LedWD !== 32'h0) begin
            failures++;
            $display("FAIL reset_out: LedWE=%b LedWD=%h want 0/00000000", LedWE, LedWD);
         end
      end else begin
         exp_we = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
         checks++;
         if (LedWE !== exp_we) begin
            failures++;
            $display("FAIL strobe @%0d: LedWE=%b want %b", cyc, LedWE, exp_we);
         end
         if (exp_we) begin
            e = sb_q.pop_front();
            checks++;
            if (LedWD !== {16'b0, e.val}) begin
               failures++;
               $display("FAIL strobe_data @%0d: LedWD=%h want %h", cyc, LedWD, {16'b0, e.val});
            end
         end
         checks++;
         if (LedWD !== {16'b0, m_shown}) begin
            failures++;
            $display("FAIL hold @%0d: LedWD=%h want %h", cyc, LedWD, {16'b0, m_shown});
         end
      end
   end

   task automatic idle(int n);
      WE = 1'b0;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      WE = 1'b1; Addr = a; WD = d;
      @(posedge CLK);
      #1;
      WE = 1'b0;
   endtask

   task automatic check_rd(string name, logic [1:0] a, logic [31:0] want);
      WE = 1'b0; Addr = a;
      #1;
      checks++;
      if (RD !== want) begin
         failures++;
         $display("FAIL rd_%s: RD=%h want %h", name, RD, want);
      end
   endtask

   initial begin
      logic [31:0] rnd;
      logic [1:0]  ra;
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b1;
      idle(1);
      check_rd("ctrl_rst", 2'd0, 32'h0);
      check_rd("pat_rst", 2'd1, 32'h0);
      check_rd("per_rst", 2'd2, 32'd5000000);
      check_rd("show_rst", 2'd3, 32'h0);

      // Static mode, then pattern update
      wr(2'd0, 32'h1);
      wr(2'd1, 32'hFFFF_A5A5);
      idle(3);
      check_rd("show_static", 2'd3, 32'h0000_A5A5);

      // Blink at period 4
      wr(2'd2, 32'd4);
      wr(2'd1, 32'h0000_00FF);
      wr(2'd0, 32'h2);
      idle(14);
      check_rd("per_4", 2'd2, 32'd4);

      // Shift left at period 3, then right
      wr(2'd2, 32'd3);
      wr(2'd1, 32'h0000_8001);
      wr(2'd0, 32'h3);
      idle(10);
      wr(2'd0, 32'h7);
      idle(4);
      check_rd("ctrl_7", 2'd0, 32'h7);

      // Period 0: step every cycle in both directions
      wr(2'd2, 32'd0);
      idle(20);
      wr(2'd0, 32'h3);
      idle(20);

      // Pattern write landing exactly on a step edge
      wr(2'd2, 32'd3);
      wr(2'd1, 32'h0000_1234);
      wr(2'd0, 32'h3);
      idle(2);
      wr(2'd1, 32'h0000_BEEF);
      idle(8);
      wr(2'd3, 32'hFFFF_FFFF);
      idle(4);

      // Reset mid-blink
      wr(2'd2, 32'd4);
      wr(2'd1, 32'h0000_0F0F);
      wr(2'd0, 32'h2);
      idle(6);
      Reset = 1'b0;
      idle(2);
      Reset = 1'b1;
      idle(10);
      check_rd("per_after_rst", 2'd2, 32'd5000000);
      check_rd("ctrl_after_rst", 2'd0, 32'h0);

      // Randomized traffic
      repeat (300) begin
         rnd = $urandom;
         ra  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            if (ra == 2'd2) rnd = (rnd & 32'hFF00_0000) | $urandom_range(0, 6);
            wr(ra, rnd);
         end else begin
            idle(1);
            check_rd("rand", ra, model_rd(ra));
         end
      end
      idle(5);

      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL leftover: queue size %0d want 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
